// File: rtl/clock_ratio_monitor.sv
// -----------------------------------------------------------------------------
// clock_ratio_monitor
//
// In-system self-check for a divided clock. The divided clock `sig` is
// synchronised into the `clk` domain and its period and high time are
// measured in `clk` cycles. Each completed period produces a one-cycle `valid`
// pulse along with two flags: a frequency error (the period differs from
// `div_exp`) and a duty error (the high time is more than half a cycle away
// from half the period). A sticky `timeout` flag reports that no rising edge
// arrived within 2*MAX_RATIO cycles.
//
// Parameters
//   MAX_RATIO   largest expected division ratio (sets timeout and counter range)
//   SYNC_STAGES depth of the input synchroniser on sig (>= 1)
//   CW          counter/output width, derived from MAX_RATIO
//
// Ports
//   clk        in   measurement clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   measurement enable; low forces IDLE and clears flags
//   div_exp    in   expected ratio, sampled when a rising edge is processed
//   sig        in   divided clock under test (asynchronous to clk)
//   period     out  last measured period in clk cycles
//   high_time  out  last measured high time in clk cycles
//   valid      out  one-cycle pulse marking new period/high_time/flags
//   freq_err   out  last period != div_exp
//   duty_err   out  |2*high_time - period| > 1
//   timeout    out  sticky: no rising edge within 2*MAX_RATIO cycles
// -----------------------------------------------------------------------------
module clock_ratio_monitor #(
    parameter int MAX_RATIO   = 64,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = $clog2(2 * MAX_RATIO + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] div_exp,
    input  logic          sig,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          valid,
    output logic          freq_err,
    output logic          duty_err,
    output logic          timeout
);

    localparam logic [CW-1:0] LIMIT = CW'(2 * MAX_RATIO);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_inc;
    logic                   hit_limit;
    logic [CW-1:0]          hi;

    // Duty check in CW+1 bits so that 2*hi cannot overflow. Odd periods
    // accept either neighbour of N/2, hence the tolerance of one.
    function automatic logic duty_bad(input logic [CW-1:0] hi_c,
                                      input logic [CW-1:0] per_c);
        logic [CW:0] twice;
        logic [CW:0] per_w;
        logic [CW:0] diff;
        twice = {hi_c, 1'b0};
        per_w = {1'b0, per_c};
        diff  = (twice >= per_w) ? (twice - per_w) : (per_w - twice);
        return diff > (CW + 1)'(1);
    endfunction

    // Input synchroniser plus one delay flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q[0] <= sig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // The counter is cleared whenever it reaches LIMIT, so it never wraps;
    // the hold at LIMIT only guards against an out-of-range value.
    assign cnt_inc   = (cnt == LIMIT) ? cnt : cnt + CW'(1);
    assign hit_limit = (cnt_inc == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hi        <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            freq_err  <= 1'b0;
            duty_err  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                // Partial period is discarded; measured values are kept.
                state    <= ST_IDLE;
                cnt      <= '0;
                hi       <= '0;
                freq_err <= 1'b0;
                duty_err <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ARM;
                        cnt   <= '0;
                    end

                    ST_ARM: begin
                        // First edge only starts timing.
                        if (rise) begin
                            state <= ST_MEASURE;
                            cnt   <= CW'(1);
                            hi    <= '0;
                        end else if (hit_limit) begin
                            timeout <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    ST_MEASURE: begin
                        if (rise) begin
                            // cnt restarts at 1 on each rise, so here it
                            // equals the number of cycles between rises.
                            period    <= cnt;
                            high_time <= hi;
                            valid     <= 1'b1;
                            freq_err  <= (cnt != div_exp);
                            duty_err  <= duty_bad(hi, cnt);
                            cnt       <= CW'(1);
                            hi        <= '0;
                        end else if (hit_limit) begin
                            timeout <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_ARM;
                        end else begin
                            if (fall) begin
                                hi <= cnt;
                            end
                            cnt <= cnt_inc;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_ratio_monitor
//
// Bench for clock_ratio_monitor. A generator produces the divided clock and
// logs the clk edge that first samples every rising edge of sig together with
// the high length of the period that starts there. The reference model derives
// expected measurements from that log: a valid is expected SYNC edges after a
// logged rise, its period is the distance to the previous logged rise, and its
// high time is the high length of that previous period.
// -----------------------------------------------------------------------------
module tb_clock_ratio_monitor;

    localparam int MAX_RATIO = 64;
    localparam int SYNC      = 2;
    localparam int CW        = $clog2(2 * MAX_RATIO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [CW-1:0] div_exp = '0;
    logic          sig = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          freq_err;
    logic          duty_err;
    logic          timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Generator state and rise log
    int gen_n  = 4;
    int gen_h  = 2;
    int cur_n  = 4;
    int cur_h  = 2;
    int ph     = 0;
    bit gen_on = 1'b0;
    int rk[$];
    int rh[$];

    clock_ratio_monitor #(
        .MAX_RATIO  (MAX_RATIO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_exp  (div_exp),
        .sig      (sig),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .freq_err (freq_err),
        .duty_err (duty_err),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // New ratio/high settings take effect at the start of the next period.
    always @(negedge clk) begin
        if (!gen_on) begin
            sig = 1'b0;
            ph  = 0;
        end else begin
            if (ph == 0) begin
                cur_n = gen_n;
                cur_h = gen_h;
                rk.push_back(cyc + 1);
                rh.push_back(gen_h);
            end
            sig = (ph < cur_h);
            ph  = (ph + 1 >= cur_n) ? 0 : ph + 1;
        end
    end

    function automatic bit model_lookup(input int e, output int per, output int hi);
        per = 0;
        hi  = 0;
        for (int i = 1; i < rk.size(); i++) begin
            if (rk[i] + SYNC == e) begin
                per = rk[i] - rk[i-1];
                hi  = rh[i-1];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit model_duty(input int per, input int hi);
        int d;
        d = 2 * hi - per;
        if (d < 0) d = -d;
        return d > 1;
    endfunction

    task automatic get_valid(input int budget, output bit got, output int e);
        got = 1'b0;
        e   = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) begin
                got = 1'b1;
                e   = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({period, high_time, valid, freq_err, duty_err, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {period, high_time, valid, freq_err, duty_err, timeout});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit got;
        int e, prev, q0, exp_e;
        gen_on = 1'b0; gen_n = 4; gen_h = 2; div_exp = 4;
        @(posedge clk); #1;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        q0 = rk.size();
        gen_on = 1'b1;
        get_valid(40, got, e);
        exp_e = (rk.size() > q0 + 1) ? rk[q0+1] + SYNC : -2;
        checks++;
        if (!got || e != exp_e) begin
            errors++;
            $display("FAIL basic_first_valid: edge %0d, want %0d", e, exp_e);
        end
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: valid %b, want 0", valid);
        end
        prev = e;
        for (int j = 0; j < 4; j++) begin
            get_valid(20, got, e);
            checks++;
            if (!got || e - prev != 4) begin
                errors++;
                $display("FAIL basic_spacing: %0d cycles, want 4", e - prev);
            end
            checks++;
            if (period !== 4 || high_time !== 2 || freq_err !== 1'b0 || duty_err !== 1'b0) begin
                errors++;
                $display("FAIL basic_values: period=%0d high=%0d f=%b d=%b, want 4 2 0 0",
                         period, high_time, freq_err, duty_err);
            end
            prev = e;
        end
    endtask

    task automatic test_duty();
        bit got;
        int e;
        gen_n = 7; gen_h = 4; div_exp = 7;
        repeat (2) get_valid(40, got, e);
        for (int j = 0; j < 3; j++) begin
            get_valid(40, got, e);
            checks++;
            if (!got || period !== 7 || high_time !== 4 || freq_err !== 1'b0 || duty_err !== 1'b0) begin
                errors++;
                $display("FAIL duty_4_3: got=%b period=%0d high=%0d f=%b d=%b, want 7 4 0 0",
                         got, period, high_time, freq_err, duty_err);
            end
        end
        gen_h = 2;
        get_valid(40, got, e);
        checks++;
        if (!got || high_time !== 4 || duty_err !== 1'b0) begin
            errors++;
            $display("FAIL duty_old_period: high=%0d d=%b, want 4 0", high_time, duty_err);
        end
        get_valid(40, got, e);
        checks++;
        if (!got || period !== 7 || high_time !== 2 || duty_err !== 1'b1) begin
            errors++;
            $display("FAIL duty_2_5: period=%0d high=%0d d=%b, want 7 2 1",
                     period, high_time, duty_err);
        end
    endtask

    task automatic test_freq();
        bit got;
        int e;
        gen_n = 6; gen_h = 3; div_exp = 5;
        repeat (2) get_valid(40, got, e);
        for (int j = 0; j < 3; j++) begin
            get_valid(40, got, e);
            checks++;
            if (!got || period !== 6 || high_time !== 3 || freq_err !== 1'b1 || duty_err !== 1'b0) begin
                errors++;
                $display("FAIL freq_mismatch: period=%0d high=%0d f=%b d=%b, want 6 3 1 0",
                         period, high_time, freq_err, duty_err);
            end
        end
        div_exp = 6;
        for (int j = 0; j < 2; j++) begin
            get_valid(40, got, e);
            checks++;
            if (!got || period !== 6 || freq_err !== 1'b0) begin
                errors++;
                $display("FAIL freq_match: period=%0d f=%b, want 6 0", period, freq_err);
            end
        end
    endtask

    task automatic test_random();
        bit got, found;
        int e, per, hi, n, h;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(24, 2);
            h = $urandom_range(n - 1, 1);
            gen_n = n;
            gen_h = h;
            div_exp = CW'($urandom_range(26, 2));
            for (int j = 0; j < 4; j++) begin
                get_valid(80, got, e);
                found = model_lookup(e, per, hi);
                checks++;
                if (!got || !found) begin
                    errors++;
                    $display("FAIL rand_valid_edge: got=%b edge=%0d matches_rise=%b, want 1 1",
                             got, e, found);
                end else begin
                    checks++;
                    if (period !== per || high_time !== hi ||
                        freq_err !== (per != int'(div_exp)) || duty_err !== model_duty(per, hi)) begin
                        errors++;
                        $display("FAIL rand_values: period=%0d high=%0d f=%b d=%b, want %0d %0d %b %b",
                                 period, high_time, freq_err, duty_err, per, hi,
                                 per != int'(div_exp), model_duty(per, hi));
                    end
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit got;
        int e, target, guard;
        gen_n = 5; gen_h = 2; div_exp = 5;
        repeat (3) get_valid(40, got, e);
        gen_on = 1'b0;
        // cnt restarts at 1 on the processed rise and times out when it
        // becomes 2*MAX_RATIO.
        target = rk[rk.size()-1] + SYNC + 2 * MAX_RATIO - 1;
        guard = 0;
        while (cyc < target - 1 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (timeout !== 1'b0 || cyc != target - 1) begin
            errors++;
            $display("FAIL timeout_early: timeout=%b at edge %0d, want 0 at %0d",
                     timeout, cyc, target - 1);
        end
        @(posedge clk); #1;
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_assert: timeout=%b, want 1", timeout);
        end
        gen_on = 1'b1;
        get_valid(40, got, e);
        checks++;
        if (!got || timeout !== 1'b1 || period !== 5) begin
            errors++;
            $display("FAIL timeout_sticky: valid=%b timeout=%b period=%0d, want 1 1 5",
                     got, timeout, period);
        end
        en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: timeout=%b, want 0", timeout);
        end
        en = 1'b1;
    endtask

    task automatic test_reenable();
        bit got, seen;
        int e, c_en, exp_e, per, hi;
        gen_n = 8; gen_h = 4; div_exp = 7;
        repeat (3) get_valid(40, got, e);
        checks++;
        if (!got || freq_err !== 1'b1 || period !== 8) begin
            errors++;
            $display("FAIL reen_setup: f=%b period=%0d, want 1 8", freq_err, period);
        end
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (freq_err !== 1'b0 || period !== 8 || high_time !== 4) begin
            errors++;
            $display("FAIL reen_idle: f=%b period=%0d high=%0d, want 0 8 4",
                     freq_err, period, high_time);
        end
        for (int j = 0; j < 3; j++) begin
            if (valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        if (valid === 1'b1) seen = 1'b1;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reen_no_valid_idle: valid seen=%b, want 0", seen);
        end
        en = 1'b1;
        c_en = cyc;
        get_valid(60, got, e);
        // ARM starts processing rises two edges after en is raised; the first
        // such rise only arms, the next produces the valid.
        exp_e = -2;
        for (int i = 0; i + 1 < rk.size(); i++) begin
            if (rk[i] + SYNC >= c_en + 2) begin
                exp_e = rk[i+1] + SYNC;
                break;
            end
        end
        checks++;
        if (!got || e != exp_e) begin
            errors++;
            $display("FAIL reen_first_valid: edge %0d, want %0d", e, exp_e);
        end
        checks++;
        if (!model_lookup(e, per, hi) || period !== per || high_time !== hi || freq_err !== 1'b1) begin
            errors++;
            $display("FAIL reen_values: period=%0d high=%0d f=%b, want %0d %0d 1",
                     period, high_time, freq_err, per, hi);
        end
    endtask

    task automatic test_async_reset();
        bit got, seen;
        int e;
        gen_n = 5; gen_h = 2; div_exp = 4;
        repeat (3) get_valid(40, got, e);
        checks++;
        if (!got || period !== 5 || freq_err !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup: period=%0d f=%b, want 5 1", period, freq_err);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({period, high_time, valid, freq_err, duty_err, timeout} !== '0) begin
            errors++;
            $display("FAIL arst_immediate: got %h, want 0",
                     {period, high_time, valid, freq_err, duty_err, timeout});
        end
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || period !== '0) begin
            errors++;
            $display("FAIL arst_idle: valid seen=%b period=%0d, want 0 0", seen, period);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty();
        test_freq();
        test_random();
        test_timeout();
        test_reenable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
